// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Constants shared between the UART receive and transmit paths.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Width of one UART character as seen by the bus side.
    localparam int UART_DATA_W = 8;

    // Default number of entries in the receive buffer.
    localparam int UART_RX_FIFO_DEPTH = 16;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_pulse_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pulse_sync
//  Description : Brings a level/pulse from the baud_clk domain into clk with a
//                two-flop synchroniser and emits a single-cycle pulse on each
//                rising edge of the synchronised signal.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse_out
);

    // r_s1/r_s2 form the metastability chain; r_s3 is the delayed copy used
    // only for edge detection and never sees the raw asynchronous input.
    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchroniser and edge-detect history; all cleared by reset so that a
    // level still high after reset is seen as a fresh rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= async_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // One pulse per assertion, however long the source stays high.
    assign pulse_out = r_s2 & ~r_s3;

endmodule : uart_pulse_sync
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Receive buffer behind the UART RX shift register. Captures a
//                byte on every synchronised rising edge of rx_done and holds
//                it in a first-word-fall-through FIFO for the bus side.
//                Reports empty, full, occupancy and a sticky overrun flag.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] rx_byte,
    input  logic                   rx_done,
    input  logic                   rd_en,
    input  logic                   clr_overrun,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [ADDR_W:0]        count,
    output logic                   overrun
);

    // Occupancy value that means "every slot used".
    localparam logic [ADDR_W:0]   c_FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE  = ADDR_W'(1);

    // ------------------------------------------------------------------
    // Storage and bookkeeping
    // ------------------------------------------------------------------
    logic [UART_DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]      r_wr_ptr;
    logic [ADDR_W-1:0]      r_rd_ptr;
    logic [ADDR_W:0]        r_count;
    logic                   r_overrun;

    logic w_push;
    logic w_empty;
    logic w_full;
    logic w_rd_ok;
    logic w_wr_ok;
    logic w_ovr_set;

    // ------------------------------------------------------------------
    // Cross rx_done into clk and turn it into a one-cycle write request.
    // The byte itself is not synchronised: the shift register keeps it
    // stable for a full baud period, far longer than the three-cycle path.
    // ------------------------------------------------------------------
    uart_pulse_sync u_done_sync (
        .clk       (clk),
        .rst       (rst),
        .async_in  (rx_done),
        .pulse_out (w_push)
    );

    // Status comes purely from the registered occupancy.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_CNT);

    // Decide which of read / write / drop happens this cycle. A read on a
    // full FIFO frees the slot the simultaneous write then takes, so that
    // case is accepted rather than counted as an overrun.
    always_comb begin
        w_rd_ok   = rd_en & ~w_empty;
        w_wr_ok   = w_push & (~w_full | w_rd_ok);
        w_ovr_set = w_push & w_full & ~w_rd_ok;
    end

    // Byte storage; deliberately not reset since nothing is readable while
    // the FIFO reports empty.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_mem[r_wr_ptr] <= rx_byte;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Occupancy tracks accepted writes minus accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            unique case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overrun; a new drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head of queue falls through, forced to zero when empty.
    // ------------------------------------------------------------------
    assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign empty   = w_empty;
    assign full    = w_full;
    assign count   = r_count;
    assign overrun = r_overrun;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo: directed scenarios with
//                literal expectations, then randomised traffic, all compared
//                every cycle against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = UART_RX_FIFO_DEPTH;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_byte;
    logic          rx_done;
    logic          rd_en;
    logic          clr_overrun;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;

    int vectors    = 0;
    int miscompares = 0;

    uart_rx_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .rx_byte     (rx_byte),
        .rx_done     (rx_done),
        .rd_en       (rd_en),
        .clr_overrun (clr_overrun),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a byte queue plus an overrun bit. rx_done samples
    // are remembered so that a rise first seen at edge N writes at N+2.
    // ------------------------------------------------------------------
    logic [7:0] mq[$];
    logic       m_ovr   = 1'b0;
    logic       m_valid = 1'b0;
    logic       hist1   = 1'b0;   // rx_done seen at previous edge
    logic       hist2   = 1'b0;   // two edges ago
    logic       hist3   = 1'b0;   // three edges ago

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_ovr   = 1'b0;
                hist1   = 1'b0;
                hist2   = 1'b0;
                hist3   = 1'b0;
                m_valid = 1'b1;
            end else begin
                logic push;
                logic rd;
                logic drop;
                push = hist2 && !hist3;
                rd   = rd_en && (mq.size() != 0);
                drop = 1'b0;
                if (rd) void'(mq.pop_front());
                if (push) begin
                    if (mq.size() < DEPTH) mq.push_back(rx_byte);
                    else drop = 1'b1;
                end
                if (drop) m_ovr = 1'b1;
                else if (clr_overrun) m_ovr = 1'b0;
                hist3 = hist2;
                hist2 = hist1;
                hist1 = rx_done;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                logic [7:0] exp_rd;
                exp_rd = (mq.size() != 0) ? mq[0] : 8'h00;
                cmp("model.rd_data", 32'(rd_data), 32'(exp_rd));
                cmp("model.count",   32'(count),   32'(mq.size()));
                cmp("model.empty",   32'(empty),   32'(mq.size() == 0));
                cmp("model.full",    32'(full),    32'(mq.size() == DEPTH));
                cmp("model.overrun", 32'(overrun), 32'(m_ovr));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; inputs change 2 time units after each rising edge.
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b, input int hi);
        rx_byte = b;
        rx_done = 1'b1;
        tick(hi);
        rx_done = 1'b0;
        tick(3);
    endtask

    // rd_en is raised exactly on the edge where the push lands.
    task automatic send_with_read(input logic [7:0] b);
        rx_byte = b;
        rx_done = 1'b1;
        tick(2);
        rd_en = 1'b1;
        tick(1);
        rd_en   = 1'b0;
        rx_done = 1'b0;
        tick(3);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    initial begin
        int low_cnt;
        int hi_left;
        int rd_pct;

        rst         = 1'b1;
        rx_byte     = 8'h00;
        rx_done     = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);

        // Reset state.
        cmp("reset.empty",   32'(empty),   32'd1);
        cmp("reset.full",    32'(full),    32'd0);
        cmp("reset.count",   32'(count),   32'd0);
        cmp("reset.overrun", 32'(overrun), 32'd0);
        cmp("reset.rd_data", 32'(rd_data), 32'h00);

        // 1: long rx_done, exactly one capture, two-edge latency.
        rx_byte = 8'hA5;
        rx_done = 1'b1;
        tick(1);
        cmp("lat.count_n",  32'(count), 32'd0);
        tick(1);
        cmp("lat.count_n1", 32'(count), 32'd0);
        tick(1);
        cmp("lat.count_n2", 32'(count),   32'd1);
        cmp("lat.data_n2",  32'(rd_data), 32'hA5);
        cmp("lat.empty_n2", 32'(empty),   32'd0);
        tick(37);
        rx_done = 1'b0;
        tick(3);
        cmp("long.count", 32'(count), 32'd1);
        pop();
        cmp("long.empty", 32'(empty),   32'd1);
        cmp("long.data",  32'(rd_data), 32'h00);

        // 2: fill to DEPTH, then drain in order.
        for (int i = 1; i <= DEPTH; i++) send(8'(i), 1);
        cmp("fill.full",    32'(full),    32'd1);
        cmp("fill.count",   32'(count),   32'(DEPTH));
        cmp("fill.overrun", 32'(overrun), 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            cmp("drain.order", 32'(rd_data), 32'(i));
            pop();
        end
        cmp("drain.empty", 32'(empty), 32'd1);

        // 3: overrun on full, byte dropped, then cleared.
        for (int i = 0; i < DEPTH; i++) send(8'(8'h20 + i), 1);
        send(8'hEE, 1);
        cmp("ovr.flag",  32'(overrun), 32'd1);
        cmp("ovr.count", 32'(count),   32'(DEPTH));
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        cmp("ovr.clear", 32'(overrun), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            cmp("ovr.drain", 32'(rd_data), 32'(8'h20 + i));
            pop();
        end
        cmp("ovr.empty", 32'(empty), 32'd1);

        // 4: push coincident with read while full.
        for (int i = 0; i < DEPTH; i++) send(8'(8'h40 + i), 1);
        send_with_read(8'h77);
        cmp("fullrw.count",   32'(count),   32'(DEPTH));
        cmp("fullrw.overrun", 32'(overrun), 32'd0);
        for (int i = 1; i < DEPTH; i++) begin
            cmp("fullrw.drain", 32'(rd_data), 32'(8'h40 + i));
            pop();
        end
        cmp("fullrw.last", 32'(rd_data), 32'h77);
        pop();
        cmp("fullrw.empty", 32'(empty), 32'd1);

        // 5: reads while empty are ignored; push+read on empty keeps byte.
        rd_en = 1'b1;
        tick(3);
        rd_en = 1'b0;
        cmp("emptyrd.count", 32'(count), 32'd0);
        send_with_read(8'h5A);
        cmp("emptyrw.count", 32'(count),   32'd1);
        cmp("emptyrw.data",  32'(rd_data), 32'h5A);
        pop();

        // 6: reset mid-stream, then normal capture.
        send(8'h11, 2);
        send(8'h22, 1);
        send(8'h33, 3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        cmp("midrst.count",   32'(count),   32'd0);
        cmp("midrst.empty",   32'(empty),   32'd1);
        cmp("midrst.overrun", 32'(overrun), 32'd0);
        send(8'h3C, 1);
        cmp("midrst.data", 32'(rd_data), 32'h3C);
        pop();

        // Randomised traffic in phases of light, balanced and heavy reading.
        low_cnt = 3;
        hi_left = 0;
        for (int ph = 0; ph < 3; ph++) begin
            rd_pct = (ph == 0) ? 10 : (ph == 1) ? 50 : 90;
            for (int c = 0; c < 1500; c++) begin
                if (hi_left > 0) begin
                    hi_left--;
                    if (hi_left == 0) rx_done = 1'b0;
                end else if (!rx_done && low_cnt >= 3 && $urandom_range(0, 2) == 0) begin
                    rx_byte = 8'($urandom);
                    rx_done = 1'b1;
                    hi_left = $urandom_range(1, 5);
                    low_cnt = 0;
                end
                if (!rx_done) low_cnt++;
                rd_en       = ($urandom_range(0, 99) < rd_pct);
                clr_overrun = ($urandom_range(0, 19) == 0);
                rst         = ($urandom_range(0, 599) == 0);
                tick(1);
            end
        end
        rst         = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        rx_done     = 1'b0;
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART RX shift register.
- Captures each completed byte on the rising edge of that stage's `shift_done` pulse. `shift_done` comes from the baud_clk domain and is synchronised into `clk`.
- Holds bytes in a first-word-fall-through FIFO that the CPU/bus side drains.
- Reports empty, full, occupancy and a sticky overrun flag.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk  input  1  system clock; all state is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_byte  input  8  received byte from the shift register; stable while rx_done is high and for at least one baud period after.
- rx_done  input  1  shift-complete pulse from the baud_clk domain; asynchronous to clk.
- rd_en  input  1  pop strobe, one byte per asserted cycle.
- clr_overrun  input  1  clears the sticky overrun flag.
- rd_data  output  8  head of FIFO; 8'h00 when empty.
- empty  output  1  FIFO holds no bytes.
- full  output  1  FIFO holds DEPTH bytes.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overrun  output  1  sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset, applied at any clk edge where rst=1, including mid-operation:
  - Synchroniser flops and edge-detect flop go to 0.
  - wr_ptr, rd_ptr and count go to 0.
  - empty=1, full=0, overrun=0, rd_data=8'h00.
  - Memory contents are not cleared; they are unobservable while empty.
- Synchroniser: rx_done passes through two flops (s1, s2) and a third flop (s3) for edge detection.
  - push = s2 & ~s3, a single-cycle pulse per rx_done assertion regardless of how long rx_done stays high.
- Latency: if rx_done is first sampled high at clk edge N, s2 rises at N+1 and the write occurs at edge N+2.
  - From the cycle after N+2: empty=0, count has incremented and rd_data shows the byte.
- rx_byte is sampled at the write edge. This is safe because the shift register holds the byte for at least one baud period (much longer than 3 clk cycles).
- Write: on push with full=0, mem[wr_ptr] is written, wr_ptr increments modulo DEPTH (natural ADDR_W wrap) and count increments.
- Read: on rd_en with empty=0, rd_ptr increments modulo DEPTH and count decrements.
  - rd_data is combinational mem[rd_ptr], gated to 0 when empty (FWFT).
- Empty read: rd_en while empty is ignored; pointers and count are unchanged and no error flag is raised.
- Simultaneous push and rd_en, not empty, not full: both happen and count is unchanged.
- Simultaneous push and rd_en while empty: the push happens and the read is ignored; count becomes 1.
- Simultaneous push and rd_en while full: the read frees the slot and the push is accepted the same cycle; count stays DEPTH and overrun is not set.
- Overrun: a push while full without rd_en drops the byte; pointers and count are unchanged and overrun is set to 1.
- overrun holds until a clk edge with clr_overrun=1. If a new overrun event and clr_overrun occur in the same cycle, set wins (overrun=1).
- Status signals:
  - empty = (count==0).
  - full = (count==DEPTH).
  - All status is derived from registered count; no combinational path from inputs.
- Reset asserted while rx_done is high: after reset releases, s3 starts at 0. One push then occurs if rx_done is still high, so the byte is captured. This is accepted behaviour.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W=8.
  - UART_RX_FIFO_DEPTH=16 (default feeding DEPTH).
  - Both are shared with the TX side.
- Sub-module uart_pulse_sync: 2-flop synchroniser plus rising-edge detector, with ports clk, rst, async_in, pulse_out.
  - Reused for any baud_clk to clk pulse crossing.
  - The FIFO memory and pointers stay inline.

Test Plan:
1. Reset, then rx_byte=8'hA5 with rx_done high for 40 clk -> exactly one push. From the cycle after edge N+2: empty=0, count=1, rd_data=8'hA5. Then rd_en for 1 cycle -> empty=1, rd_data=8'h00.
2. Push 8'h01..8'h10 (16 bytes, DEPTH=16) -> full=1, count=16, overrun=0. Pop all 16 -> data out in order 01..10, and pointers wrap back to 0.
3. With the FIFO full, push 8'hEE without rd_en -> overrun=1, count=16, 8'hEE never read. Then clr_overrun for 1 cycle -> overrun=0.
4. With the FIFO full, push 8'h77 coincident with rd_en -> count stays 16, overrun=0, 8'h77 is the last byte read out.
5. With the FIFO empty, rd_en for 3 cycles -> count=0, pointers unchanged. Push with rd_en in the same cycle -> count=1 and the byte is retained.
6. Push 3 bytes, assert rst for 1 cycle mid-stream -> count=0, empty=1, overrun=0. The next push of 8'h3C reads back 8'h3C.
